// File: rtl/eth_pkt_gen.sv
// eth_pkt_gen: Avalon-ST 64-bit Ethernet test-frame generator.
// Produces programmable-length, sequence-numbered frames under ready/valid
// backpressure. Every output is driven straight from a register.
module eth_pkt_gen #(
    parameter logic [47:0] DST_MAC   = 48'hFFFF_FFFF_FFFF,
    parameter logic [47:0] SRC_MAC   = 48'h0002_0304_0506,
    parameter logic [15:0] ETHERTYPE = 16'h88B5,
    parameter int unsigned MIN_LEN   = 60,
    parameter int unsigned MAX_LEN   = 9600
) (
    input  logic        clk_156_in_clk_clk,
    input  logic        rst_in_reset_reset,
    input  logic        start,
    input  logic        stop,
    input  logic [13:0] pkt_len,
    input  logic [31:0] pkt_count,
    input  logic [7:0]  gap_cycles,
    output logic        busy,
    output logic        done,
    output logic [31:0] pkts_sent,
    output logic [63:0] tx_st_data,
    output logic        tx_st_valid,
    input  logic        tx_st_ready,
    output logic        tx_st_startofpacket,
    output logic        tx_st_endofpacket,
    output logic [2:0]  tx_st_empty,
    output logic        tx_st_error
);

    typedef enum logic [1:0] {S_IDLE, S_SEND, S_GAP} state_e;

    state_e      state_q, state_d;
    logic [10:0] words_q, words_d;          // beats per frame, up to 1200
    logic [2:0]  last_empty_q, last_empty_d;
    logic [31:0] count_q, count_d;
    logic [7:0]  gap_q, gap_d;
    logic [7:0]  gap_cnt_q, gap_cnt_d;
    logic [10:0] idx_q, idx_d;
    logic [31:0] seq_q, seq_d;
    logic [31:0] sent_q, sent_d;
    logic        stop_seen_q, stop_seen_d;
    logic        done_q, done_d;
    logic        busy_q, busy_d;
    logic        valid_q, valid_d;
    logic        sop_q, sop_d;
    logic        eop_q, eop_d;
    logic [2:0]  empty_q, empty_d;
    logic [63:0] data_q, data_d;

    logic [13:0] len_c;
    logic [10:0] words_c;
    logic [2:0]  empty_c;
    logic        xfer;
    logic        stop_req;

    // Frame word at beat index idx of frame number seq.
    function automatic logic [63:0] frame_word(input logic [10:0] idx, input logic [31:0] seq);
        logic [15:0] i16;
        i16 = {5'd0, idx};
        if (idx == 11'd0)
            return {DST_MAC, SRC_MAC[47:32]};
        else if (idx == 11'd1)
            return {SRC_MAC[31:0], ETHERTYPE, seq[31:16]};
        else
            return {seq[15:0], i16, ~seq[15:0], ~i16};
    endfunction

    // Clamp the requested length and derive beat count and eop empty bytes.
    always_comb begin
        len_c = pkt_len;
        if (pkt_len < 14'(MIN_LEN))
            len_c = 14'(MIN_LEN);
        else if (pkt_len > 14'(MAX_LEN))
            len_c = 14'(MAX_LEN);
        words_c = 11'(({1'b0, len_c} + 15'd7) >> 3);
        empty_c = 3'(4'd8 - {1'b0, len_c[2:0]});
    end

    // Next-state and next-output logic for the IDLE/SEND/GAP controller.
    always_comb begin
        // NOTE: every variable gets a default first so no path leaves one unassigned, which would infer a latch.
        state_d      = state_q;
        words_d      = words_q;
        last_empty_d = last_empty_q;
        count_d      = count_q;
        gap_d        = gap_q;
        gap_cnt_d    = gap_cnt_q;
        idx_d        = idx_q;
        seq_d        = seq_q;
        sent_d       = sent_q;
        stop_seen_d  = stop_seen_q;
        done_d       = 1'b0;
        valid_d      = valid_q;
        sop_d        = sop_q;
        eop_d        = eop_q;
        empty_d      = empty_q;
        data_d       = data_q;
        xfer         = valid_q & tx_st_ready;
        stop_req     = stop_seen_q | stop;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    words_d      = words_c;
                    last_empty_d = empty_c;
                    count_d      = pkt_count;
                    gap_d        = gap_cycles;
                    sent_d       = 32'd0;
                    seq_d        = 32'd0;
                    stop_seen_d  = 1'b0;
                    idx_d        = 11'd0;
                    state_d      = S_SEND;
                    valid_d      = 1'b1;
                    sop_d        = 1'b1;
                    eop_d        = 1'b0;
                    empty_d      = 3'd0;
                    data_d       = frame_word(11'd0, 32'd0);
                end
            end
            S_SEND: begin
                stop_seen_d = stop_req;
                if (xfer) begin
                    if (eop_q) begin
                        sent_d  = sent_q + 32'd1;
                        seq_d   = seq_q + 32'd1;
                        idx_d   = 11'd0;
                        sop_d   = 1'b0;
                        eop_d   = 1'b0;
                        empty_d = 3'd0;
                        if (stop_req || (count_q != 32'd0 && (sent_q + 32'd1) == count_q)) begin
                            state_d     = S_IDLE;
                            valid_d     = 1'b0;
                            done_d      = 1'b1;
                            stop_seen_d = 1'b0;
                        end else if (gap_q == 8'd0) begin
                            valid_d = 1'b1;
                            sop_d   = 1'b1;
                            data_d  = frame_word(11'd0, seq_q + 32'd1);
                        end else begin
                            state_d   = S_GAP;
                            gap_cnt_d = gap_q;
                            valid_d   = 1'b0;
                        end
                    end else begin
                        idx_d   = idx_q + 11'd1;
                        data_d  = frame_word(idx_q + 11'd1, seq_q);
                        sop_d   = 1'b0;
                        eop_d   = (idx_q + 11'd2) == words_q;
                        empty_d = ((idx_q + 11'd2) == words_q) ? last_empty_q : 3'd0;
                    end
                end
            end
            S_GAP: begin
                stop_seen_d = stop_req;
                if (stop_req) begin
                    state_d     = S_IDLE;
                    done_d      = 1'b1;
                    stop_seen_d = 1'b0;
                end else if (gap_cnt_q == 8'd1) begin
                    state_d = S_SEND;
                    idx_d   = 11'd0;
                    valid_d = 1'b1;
                    sop_d   = 1'b1;
                    data_d  = frame_word(11'd0, seq_q);
                end else begin
                    gap_cnt_d = gap_cnt_q - 8'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        busy_d = (state_d != S_IDLE);
    end

    // State and output registers with asynchronous active-high reset.
    always_ff @(posedge clk_156_in_clk_clk or posedge rst_in_reset_reset) begin
        if (rst_in_reset_reset) begin
            state_q      <= S_IDLE;
            words_q      <= '0;
            last_empty_q <= '0;
            count_q      <= '0;
            gap_q        <= '0;
            gap_cnt_q    <= '0;
            idx_q        <= '0;
            seq_q        <= '0;
            sent_q       <= '0;
            stop_seen_q  <= 1'b0;
            done_q       <= 1'b0;
            busy_q       <= 1'b0;
            valid_q      <= 1'b0;
            sop_q        <= 1'b0;
            eop_q        <= 1'b0;
            empty_q      <= '0;
            data_q       <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values, independent of statement order.
            state_q      <= state_d;
            words_q      <= words_d;
            last_empty_q <= last_empty_d;
            count_q      <= count_d;
            gap_q        <= gap_d;
            gap_cnt_q    <= gap_cnt_d;
            idx_q        <= idx_d;
            seq_q        <= seq_d;
            sent_q       <= sent_d;
            stop_seen_q  <= stop_seen_d;
            done_q       <= done_d;
            busy_q       <= busy_d;
            valid_q      <= valid_d;
            sop_q        <= sop_d;
            eop_q        <= eop_d;
            empty_q      <= empty_d;
            data_q       <= data_d;
        end
    end

    assign busy                = busy_q;
    assign done                = done_q;
    assign pkts_sent           = sent_q;
    assign tx_st_data          = data_q;
    assign tx_st_valid         = valid_q;
    assign tx_st_startofpacket = sop_q;
    assign tx_st_endofpacket   = eop_q;
    assign tx_st_empty         = empty_q;
    assign tx_st_error         = 1'b0;

endmodule

// File: tb/tb_eth_pkt_gen.sv
// tb_eth_pkt_gen: randomized self-checking bench for eth_pkt_gen.
// The reference model builds each frame byte by byte from the frame layout
// and predicts beat timing from frame length and gap arithmetic.
module tb_eth_pkt_gen;

    localparam logic [47:0] DST = 48'hFFFF_FFFF_FFFF;
    localparam logic [47:0] SRC = 48'h0002_0304_0506;
    localparam logic [15:0] ETT = 16'h88B5;

    typedef struct {
        logic [63:0] data;
        logic        sop;
        logic        eop;
        logic [2:0]  empty;
        int          cyc;
    } beat_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic [13:0] pkt_len = '0;
    logic [31:0] pkt_count = '0;
    logic [7:0]  gap_cycles = '0;
    logic        busy, done;
    logic [31:0] pkts_sent;
    logic [63:0] tx_st_data;
    logic        tx_st_valid;
    logic        tx_st_ready = 1'b0;
    logic        tx_st_startofpacket, tx_st_endofpacket;
    logic [2:0]  tx_st_empty;
    logic        tx_st_error;

    int    errors = 0;
    int    checks = 0;
    beat_t got_q[$];
    beat_t exp_q[$];
    int    done_q[$];
    int    stall_bad;
    int    stop_cyc;

    eth_pkt_gen dut (
        .clk_156_in_clk_clk (clk),
        .rst_in_reset_reset (rst),
        .start              (start),
        .stop               (stop),
        .pkt_len            (pkt_len),
        .pkt_count          (pkt_count),
        .gap_cycles         (gap_cycles),
        .busy               (busy),
        .done               (done),
        .pkts_sent          (pkts_sent),
        .tx_st_data         (tx_st_data),
        .tx_st_valid        (tx_st_valid),
        .tx_st_ready        (tx_st_ready),
        .tx_st_startofpacket(tx_st_startofpacket),
        .tx_st_endofpacket  (tx_st_endofpacket),
        .tx_st_empty        (tx_st_empty),
        .tx_st_error        (tx_st_error)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    function automatic int clamp_len(input int len);
        if (len < 60) return 60;
        if (len > 9600) return 9600;
        return len;
    endfunction

    // Byte n on the wire of frame number seq.
    function automatic logic [7:0] byte_at(input int n, input logic [31:0] seq);
        logic [15:0] fld;
        logic [15:0] i16;
        int off;
        if (n < 6)  return 8'(DST >> (8 * (5 - n)));
        if (n < 12) return 8'(SRC >> (8 * (11 - n)));
        if (n < 14) return 8'(ETT >> (8 * (13 - n)));
        if (n < 16) return 8'(seq >> (8 * (17 - n)));
        i16 = 16'(n / 8);
        off = n % 8;
        case (off / 2)
            0:       fld = seq[15:0];
            1:       fld = i16;
            2:       fld = ~seq[15:0];
            default: fld = ~i16;
        endcase
        return (off % 2 == 0) ? fld[15:8] : fld[7:0];
    endfunction

    function automatic logic [63:0] word_of(input int j, input logic [31:0] seq);
        logic [63:0] w;
        w = '0;
        for (int k = 0; k < 8; k++) w = {w[55:0], byte_at(8 * j + k, seq)};
        return w;
    endfunction

    // Expected beats for nframes frames; cyc counted from the first sop with ready held high.
    function automatic void build_expected(input int len, input int nframes, input int gap);
        int lc, w;
        beat_t b;
        lc = clamp_len(len);
        w  = (lc + 7) / 8;
        exp_q.delete();
        for (int f = 0; f < nframes; f++) begin
            for (int j = 0; j < w; j++) begin
                b.data  = word_of(j, 32'(f));
                b.sop   = (j == 0);
                b.eop   = (j == w - 1);
                b.empty = (j == w - 1) ? 3'(w * 8 - lc) : 3'd0;
                b.cyc   = f * (w + gap) + j;
                exp_q.push_back(b);
            end
        end
    endfunction

    // Index of the first beat where got and expected streams differ, -1 if none.
    function automatic int first_diff(input bit timed);
        for (int j = 0; j < exp_q.size() && j < got_q.size(); j++) begin
            if (got_q[j].data !== exp_q[j].data || got_q[j].sop !== exp_q[j].sop ||
                got_q[j].eop !== exp_q[j].eop || got_q[j].empty !== exp_q[j].empty ||
                (timed && got_q[j].cyc != exp_q[j].cyc))
                return j;
        end
        return -1;
    endfunction

    // ---------------- stimulus / capture ----------------
    task automatic do_start(input int len, input int count, input int gap, input bit with_stop);
        pkt_len    = 14'(len);
        pkt_count  = 32'(count);
        gap_cycles = 8'(gap);
        start      = 1'b1;
        stop       = with_stop;
        @(posedge clk); #1;
        start      = 1'b0;
        stop       = 1'b0;
    endtask

    // Captures accepted beats until 6 cycles after done, or the budget runs out.
    // rmode: 0 ready high, 1 fixed 1,0,0,1,0,1 pattern, 2 random.
    task automatic capture(input int budget, input int rmode, input int stop_beat, input int stop_gap_frames);
        bit         pat[6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        logic [69:0] prev, cur;
        bit         prev_stall, stop_sent, r;
        int         beats, eops, after_done;
        beat_t      b;
        prev = '0; prev_stall = 0; stop_sent = 0; beats = 0; eops = 0; after_done = -1;
        got_q.delete(); done_q.delete(); stall_bad = 0; stop_cyc = -1;
        for (int cyc = 0; cyc < budget; cyc++) begin
            cur = {tx_st_valid, tx_st_data, tx_st_startofpacket, tx_st_endofpacket, tx_st_empty};
            if (prev_stall && cur !== prev) stall_bad++;
            if (done === 1'b1) begin
                done_q.push_back(cyc);
                if (after_done < 0) after_done = 6;
            end
            if (after_done == 0) break;
            if (after_done > 0) after_done--;
            case (rmode)
                0:       r = 1'b1;
                1:       r = pat[cyc % 6];
                default: r = 1'($urandom_range(0, 1));
            endcase
            stop = 1'b0;
            if (!stop_sent && stop_beat >= 0 && beats == stop_beat) begin
                stop = 1'b1; stop_sent = 1; stop_cyc = cyc;
            end
            if (!stop_sent && stop_gap_frames > 0 && eops == stop_gap_frames &&
                busy === 1'b1 && tx_st_valid === 1'b0) begin
                stop = 1'b1; stop_sent = 1; stop_cyc = cyc;
            end
            tx_st_ready = r;
            if (tx_st_valid === 1'b1 && r) begin
                b.data = tx_st_data; b.sop = tx_st_startofpacket; b.eop = tx_st_endofpacket;
                b.empty = tx_st_empty; b.cyc = cyc;
                got_q.push_back(b);
                beats++;
                if (tx_st_endofpacket === 1'b1) eops++;
            end
            prev_stall = (tx_st_valid === 1'b1) && !r;
            prev = cur;
            @(posedge clk); #1;
        end
        stop = 1'b0;
        tx_st_ready = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        #12;
        if ({tx_st_valid, tx_st_startofpacket, tx_st_endofpacket, tx_st_empty} !== 6'd0) begin
            $display("FAIL reset_ctrl: valid/sop/eop/empty=%b want 0", {tx_st_valid, tx_st_startofpacket, tx_st_endofpacket, tx_st_empty}); errors++;
        end
        checks++;
        if (tx_st_data !== 64'd0) begin
            $display("FAIL reset_data: got %h want 0", tx_st_data); errors++;
        end
        checks++;
        if ({busy, done, pkts_sent, tx_st_error} !== 35'd0) begin
            $display("FAIL reset_status: busy=%b done=%b pkts_sent=%0d error=%b want all 0", busy, done, pkts_sent, tx_st_error); errors++;
        end
        checks++;
        @(posedge clk); #1; rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_single();
        int d;
        do_start(64, 1, 0, 0);
        if (tx_st_valid !== 1'b1 || tx_st_startofpacket !== 1'b1) begin
            $display("FAIL single_latency: valid=%b sop=%b want 1 1", tx_st_valid, tx_st_startofpacket); errors++;
        end
        checks++;
        capture(100, 0, -1, 0);
        build_expected(64, 1, 0);
        if (got_q.size() != 8) begin
            $display("FAIL single_beats: got %0d want 8", got_q.size()); errors++;
        end
        checks++;
        if (got_q.size() == 0 || got_q[0].data !== 64'hFFFF_FFFF_FFFF_0002) begin
            $display("FAIL single_word0: got %h want ffffffffffff0002", got_q.size() ? got_q[0].data : 64'd0); errors++;
        end
        checks++;
        d = first_diff(1);
        if (d >= 0) begin
            $display("FAIL single_stream: beat %0d got %h/%b%b/%0d@%0d want %h/%b%b/%0d@%0d", d,
                     got_q[d].data, got_q[d].sop, got_q[d].eop, got_q[d].empty, got_q[d].cyc,
                     exp_q[d].data, exp_q[d].sop, exp_q[d].eop, exp_q[d].empty, exp_q[d].cyc); errors++;
        end
        checks++;
        if (done_q.size() != 1 || done_q[0] != 8) begin
            $display("FAIL single_done: pulses=%0d first@%0d want 1 pulse @8", done_q.size(), done_q.size() ? done_q[0] : -1); errors++;
        end
        checks++;
        if (pkts_sent !== 32'd1 || busy !== 1'b0) begin
            $display("FAIL single_status: pkts_sent=%0d busy=%b want 1 0", pkts_sent, busy); errors++;
        end
        checks++;
    endtask

    task automatic test_lengths();
        int lens[6] = '{61, 65, 30, 16000, 0, 0};
        int wexp[4] = '{8, 9, 8, 1200};
        int eexp[4] = '{3, 7, 4, 0};
        int d;
        lens[4] = int'($urandom_range(0, 16383));
        lens[5] = int'($urandom_range(60, 300));
        for (int t = 0; t < 6; t++) begin
            do_start(lens[t], 1, 0, 0);
            capture(1300, 0, -1, 0);
            build_expected(lens[t], 1, 0);
            if (t < 4) begin
                if (got_q.size() != wexp[t] || got_q.size() == 0 || got_q[got_q.size() - 1].empty !== 3'(eexp[t])) begin
                    $display("FAIL len_%0d_shape: beats=%0d empty=%0d want %0d %0d", lens[t], got_q.size(),
                             got_q.size() ? got_q[got_q.size() - 1].empty : 3'd0, wexp[t], eexp[t]); errors++;
                end
                checks++;
            end
            d = first_diff(1);
            if (d >= 0 || got_q.size() != exp_q.size()) begin
                $display("FAIL len_%0d_stream: beats=%0d want %0d first diff %0d", lens[t], got_q.size(), exp_q.size(), d); errors++;
            end
            checks++;
        end
    endtask

    task automatic test_backpressure();
        int len, d;
        for (int m = 1; m <= 2; m++) begin
            len = int'($urandom_range(60, 200));
            do_start(len, 2, m - 1, 0);
            capture(2000, m, -1, 0);
            build_expected(len, 2, m - 1);
            d = first_diff(0);
            if (d >= 0 || got_q.size() != exp_q.size()) begin
                $display("FAIL bp_mode%0d_stream: len=%0d beats=%0d want %0d first diff %0d", m, len, got_q.size(), exp_q.size(), d); errors++;
            end
            checks++;
            if (stall_bad != 0) begin
                $display("FAIL bp_mode%0d_stall: %0d unstable stall cycles want 0", m, stall_bad); errors++;
            end
            checks++;
            if (pkts_sent !== 32'd2 || done_q.size() != 1) begin
                $display("FAIL bp_mode%0d_status: pkts_sent=%0d done pulses=%0d want 2 1", m, pkts_sent, done_q.size()); errors++;
            end
            checks++;
        end
    endtask

    task automatic test_multi_gap();
        int len, cnt, gap, d;
        for (int r = 0; r < 2; r++) begin
            len = (r == 0) ? 64 : int'($urandom_range(60, 150));
            cnt = (r == 0) ? 3 : int'($urandom_range(2, 4));
            gap = (r == 0) ? 4 : int'($urandom_range(1, 20));
            // second run also raises stop together with start: start must win
            do_start(len, cnt, gap, r == 1);
            capture(2000, 0, -1, 0);
            build_expected(len, cnt, gap);
            d = first_diff(1);
            if (d >= 0 || got_q.size() != exp_q.size()) begin
                $display("FAIL gap%0d_stream: len=%0d cnt=%0d gap=%0d beats=%0d want %0d first diff %0d", r, len, cnt, gap, got_q.size(), exp_q.size(), d); errors++;
            end
            checks++;
            if (pkts_sent !== 32'(cnt) || done_q.size() != 1) begin
                $display("FAIL gap%0d_status: pkts_sent=%0d done pulses=%0d want %0d 1", r, pkts_sent, done_q.size(), cnt); errors++;
            end
            checks++;
        end
    endtask

    task automatic test_stop_continuous();
        int d;
        do_start(64, 0, 0, 0);
        capture(500, 0, 5 * 8 + 3, 0);
        build_expected(64, 6, 0);
        d = first_diff(1);
        if (d >= 0 || got_q.size() != exp_q.size()) begin
            $display("FAIL stop_send_stream: beats=%0d want %0d first diff %0d", got_q.size(), exp_q.size(), d); errors++;
        end
        checks++;
        if (pkts_sent !== 32'd6 || done_q.size() != 1 || got_q.size() == 0 ||
            done_q[0] != got_q[got_q.size() - 1].cyc + 1) begin
            $display("FAIL stop_send_status: pkts_sent=%0d done pulses=%0d want 6 1 after last eop", pkts_sent, done_q.size()); errors++;
        end
        checks++;
    endtask

    task automatic test_stop_gap();
        int d;
        do_start(60, 0, 6, 0);
        capture(500, 0, -1, 2);
        build_expected(60, 2, 6);
        d = first_diff(1);
        if (d >= 0 || got_q.size() != exp_q.size()) begin
            $display("FAIL stop_gap_stream: beats=%0d want %0d first diff %0d", got_q.size(), exp_q.size(), d); errors++;
        end
        checks++;
        if (pkts_sent !== 32'd2 || done_q.size() != 1 || stop_cyc < 0 || done_q[0] != stop_cyc + 1) begin
            $display("FAIL stop_gap_status: pkts_sent=%0d done pulses=%0d stop@%0d want 2 1 done next cycle", pkts_sent, done_q.size(), stop_cyc); errors++;
        end
        checks++;
    endtask

    task automatic test_reset_midframe();
        int d;
        tx_st_ready = 1'b1;
        do_start(60, 0, 0, 0);
        repeat (19) begin @(posedge clk); #1; end
        if (pkts_sent !== 32'd2) begin
            $display("FAIL rst_pre_sent: got %0d want 2", pkts_sent); errors++;
        end
        checks++;
        rst = 1'b1;
        #1;
        if (tx_st_valid !== 1'b0 || busy !== 1'b0 || pkts_sent !== 32'd0 || tx_st_endofpacket !== 1'b0) begin
            $display("FAIL rst_async: valid=%b busy=%b pkts_sent=%0d eop=%b want 0 0 0 0", tx_st_valid, busy, pkts_sent, tx_st_endofpacket); errors++;
        end
        checks++;
        tx_st_ready = 1'b0;
        @(posedge clk); #1; rst = 1'b0;
        @(posedge clk); #1;
        do_start(100, 1, 0, 0);
        capture(200, 0, -1, 0);
        build_expected(100, 1, 0);
        d = first_diff(1);
        if (d >= 0 || got_q.size() != exp_q.size() || pkts_sent !== 32'd1) begin
            $display("FAIL rst_restart: beats=%0d want %0d diff %0d pkts_sent=%0d want 1", got_q.size(), exp_q.size(), d, pkts_sent); errors++;
        end
        checks++;
    endtask

    initial begin
        test_reset();
        test_single();
        test_lengths();
        test_backpressure();
        test_multi_gap();
        test_stop_continuous();
        test_stop_gap();
        test_reset_midframe();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
